// File: rtl/ifu_mem_responder_if.sv
// ifu_mem_responder_if: fetch, exec read/write and status signals of the instruction/data memory
interface ifu_mem_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_valid;
  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic [15:0]           fetch_count;
  logic                  proto_err;
  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    input  ifu_rd_data, ifu_rd_valid, exec_rd_data, fetch_count, proto_err
  );
  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    output ifu_rd_data, ifu_rd_valid, exec_rd_data, fetch_count, proto_err
  );
endinterface

// File: rtl/ifu_mem_responder.sv
// ifu_mem_responder: word memory serving a pipelined fetch port and a single-cycle exec read/write port
module ifu_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  ifu_mem_responder_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [RD_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0] r_dat [RD_LATENCY];
  logic [DATA_WIDTH-1:0] r_exec;
  logic [15:0]           r_cnt;
  logic                  r_prev_req;
  logic                  r_err;
  logic [RD_LATENCY-1:0] w_vld_in;
  logic [DATA_WIDTH-1:0] w_dat_in [RD_LATENCY];
  logic                  w_fetch_hit;
  logic                  w_exec_hit;

  assign w_fetch_hit = bus.exec_wr_req && (bus.exec_wr_addr == bus.ifu_rd_addr);
  assign w_exec_hit  = bus.exec_wr_req && (bus.exec_wr_addr == bus.exec_rd_addr);

  // stage 0 captures the word (write-first) at the request edge; later stages just shift it along
  always_comb begin
    w_vld_in = '0;
    w_dat_in = '{default: '0};
    w_vld_in[0] = bus.ifu_rd_req;
    w_dat_in[0] = w_fetch_hit ? bus.exec_wr_data : r_mem[bus.ifu_rd_addr];
    for (int i = 1; i < RD_LATENCY; i++) begin
      w_vld_in[i] = r_vld[i-1];
      w_dat_in[i] = r_dat[i-1];
    end
  end

  // memory writes; contents deliberately survive reset
  always_ff @(posedge clk)
    if (!reset && bus.exec_wr_req) r_mem[bus.exec_wr_addr] <= bus.exec_wr_data;

  // fetch pipeline; a stage only loads on a valid entry so the last stage holds the previous response
  always_ff @(posedge clk)
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld <= w_vld_in;
      for (int i = 0; i < RD_LATENCY; i++) if (w_vld_in[i]) r_dat[i] <= w_dat_in[i];
    end

  // exec read result, fetch response counter (moves with the valid pulse) and sticky protocol error
  always_ff @(posedge clk)
    if (reset) begin
      r_exec     <= '0;
      r_cnt      <= '0;
      r_prev_req <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (bus.exec_rd_req) r_exec <= w_exec_hit ? bus.exec_wr_data : r_mem[bus.exec_rd_addr];
      if (w_vld_in[RD_LATENCY-1]) r_cnt <= r_cnt + 16'd1;
      r_prev_req <= bus.ifu_rd_req;
      if (bus.ifu_rd_req && r_prev_req) r_err <= 1'b1;
    end

  assign bus.ifu_rd_valid = r_vld[RD_LATENCY-1];
  assign bus.ifu_rd_data  = r_dat[RD_LATENCY-1];
  assign bus.exec_rd_data = r_exec;
  assign bus.fetch_count  = r_cnt;
  assign bus.proto_err    = r_err;
endmodule
